// File: rtl/mem_write_buffer.sv
// In-order store buffer. It aligns sub-word stores into byte-enabled memory writes
// and drains them one per cycle, with load-hazard lookup and flush.
module mem_write_buffer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      st_valid,
  output logic                      st_ready,
  input  logic [ADDR_WIDTH-1:0]     st_addr,
  input  logic [DATA_WIDTH-1:0]     st_data,
  input  logic [1:0]                st_size,
  output logic                      st_misaligned,
  input  logic                      flush,
  output logic [DATA_WIDTH/8-1:0]   mem_wr_en,
  output logic [ADDR_WIDTH-1:0]     mem_wr_addr,
  output logic [DATA_WIDTH-1:0]     mem_wr_data,
  input  logic                      mem_wr_ready,
  input  logic [ADDR_WIDTH-1:0]     ld_addr,
  output logic                      ld_hit,
  output logic [$clog2(DEPTH):0]    count,
  output logic                      empty
);

  localparam int WE    = DATA_WIDTH / 8;
  localparam int OFS   = $clog2(WE);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(WE - 1);

  logic [ADDR_WIDTH-1:0] r_addr [DEPTH];
  logic [WE-1:0]         r_mask [DEPTH];
  logic [DATA_WIDTH-1:0] r_data [DEPTH];
  logic [PTR_W-1:0]      r_wptr;
  logic [PTR_W-1:0]      r_rptr;
  logic [CNT_W-1:0]      r_count;

  logic [ADDR_WIDTH-1:0] w_amask;
  logic                  w_too_big;
  logic                  w_legal;
  logic [OFS-1:0]        w_off;
  logic [WE-1:0]         w_base_mask;
  logic [DATA_WIDTH-1:0] w_keep;
  logic [WE-1:0]         w_mask;
  logic [DATA_WIDTH-1:0] w_data;
  logic                  w_full;
  logic                  w_push;
  logic                  w_pop;
  logic                  w_ld_hit;
  logic [ADDR_WIDTH-1:0] w_ld_word;

  always_comb begin
    w_amask     = (ADDR_WIDTH'(1) << st_size) - ADDR_WIDTH'(1);
    w_too_big   = (32'd1 << st_size) > 32'(WE);
    w_legal     = !w_too_big && ((st_addr & w_amask) == '0);
    w_off       = st_addr[OFS-1:0];
    w_base_mask = '0;
    w_keep      = '0;
    for (int i = 0; i < WE; i++) begin
      w_base_mask[i]    = (32'(i) < (32'd1 << st_size));
      w_keep[8*i +: 8]  = {8{w_base_mask[i]}};
    end
    w_mask = w_base_mask << w_off;
    w_data = (st_data & w_keep) << {w_off, 3'b000};
  end

  assign w_full        = (r_count == CNT_W'(DEPTH));
  assign st_ready      = !w_full;
  assign empty         = (r_count == '0);
  assign count         = r_count;
  assign st_misaligned = st_valid && !w_legal;

  // Head is read straight from storage; an empty buffer presents all zeros.
  assign mem_wr_en   = empty ? '0 : r_mask[r_rptr];
  assign mem_wr_addr = empty ? '0 : r_addr[r_rptr];
  assign mem_wr_data = empty ? '0 : r_data[r_rptr];

  assign w_push = st_valid && st_ready && w_legal;
  assign w_pop  = (|mem_wr_en) && mem_wr_ready;

  always_comb begin
    logic [PTR_W-1:0] rel;
    w_ld_word = ld_addr & ALIGN_MASK;
    w_ld_hit  = 1'b0;
    rel       = '0;
    for (int i = 0; i < DEPTH; i++) begin
      rel = PTR_W'(i) - r_rptr;
      if (({1'b0, rel} < r_count) && (r_addr[i] == w_ld_word)) w_ld_hit = 1'b1;
    end
  end

  assign ld_hit = w_ld_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry storage carries no reset; validity comes only from the pointers and count.
  always_ff @(posedge clk) begin
    if (w_push && !flush) begin
      r_addr[r_wptr] <= st_addr & ALIGN_MASK;
      r_mask[r_wptr] <= w_mask;
      r_data[r_wptr] <= w_data;
    end
  end

endmodule

// File: doc/mem_write_buffer.md
Name: mem_write_buffer

Overview:
Parametrised store buffer between the core's store path and a byte-enabled memory write port. Accepts sub-word stores (byte/half/word, up to DATA_WIDTH) with a valid/ready handshake, converts them to aligned address, byte-enable mask and lane-placed data, and queues up to DEPTH entries in order. Drains the entries to memory as the memory accepts them. Also provides a load-hazard lookup, a misalignment flag and a flush for squashed stores.

Parameters:
DATA_WIDTH, 32, memory data width in bits; multiple of 8, power of 2, >=16.
ADDR_WIDTH, 32, byte address width.
DEPTH, 4, number of FIFO entries; power of 2, >=2.
(derived) WR_EN_WIDTH = DATA_WIDTH/8; OFS = log2(WR_EN_WIDTH); CNT_W = log2(DEPTH)+1.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  asynchronous active-low reset.
st_valid  in  1  store request valid.
st_ready  out  1  buffer can accept a store; equals !full.
st_addr  in  ADDR_WIDTH  store byte address.
st_data  in  DATA_WIDTH  store data, right-justified.
st_size  in  2  log2(bytes): 0=byte, 1=half, 2=word, 3=dword.
st_misaligned  out  1  combinational: st_valid with an illegal size/alignment.
flush  in  1  synchronous discard of all queued entries.
mem_wr_en  out  WR_EN_WIDTH  byte enables of head entry; nonzero means a write is presented.
mem_wr_addr  out  ADDR_WIDTH  head entry word-aligned address.
mem_wr_data  out  DATA_WIDTH  head entry lane-placed data.
mem_wr_ready  in  1  memory accepts the presented write this cycle.
ld_addr  in  ADDR_WIDTH  load address to check.
ld_hit  out  1  combinational: a queued entry covers ld_addr's word.
count  out  CNT_W  number of queued entries.
empty  out  1  count==0.

Behaviour:
- Reset (rst_n low, asynchronous): pointers and count 0; mem_wr_en/addr/data 0; empty=1; st_ready=1; entry storage need not be cleared.
- Illegal store: (1<<st_size) > WR_EN_WIDTH, or st_addr[st_size-1:0] != 0. Then st_misaligned=st_valid. When st_ready=1 the handshake completes but nothing is enqueued. st_misaligned ignores st_ready.
- Push: st_valid & st_ready & legal.
- Entry fields: addr = st_addr with low OFS bits cleared; off = st_addr[OFS-1:0].
  - mask = ((1<<(1<<st_size))-1) << off.
  - data = (st_data & low 8*(1<<st_size) bits) << (8*off); non-enabled lanes are 0.
- Pop: mem_wr_en != 0 & mem_wr_ready.
- Outputs are driven from the registered head entry. A push at edge N is visible on the memory port in the cycle after edge N when the buffer was empty. There is no bypass.
- When empty, mem_wr_en/addr/data = 0.
- Throughput: one pop per cycle. Writes leave in strict acceptance order.
- Push and pop in the same cycle: count unchanged. Push is impossible when full (st_ready=0), even if a pop occurs that cycle.
- Pointers wrap modulo DEPTH. count ranges 0..DEPTH.
- flush=1 at edge: count, read and write pointers go to 0. Any push in that cycle is discarded. A pop in that cycle counts as completed, because the memory saw it. In the next cycle mem_wr_en=0.
- ld_hit: OR over valid entries of (entry.addr == ld_addr with low OFS bits cleared). The head is included even while it is popping (conservative). A store being pushed this cycle is excluded. ld_hit=0 when empty.
- mem_wr_addr/data/en stay stable while mem_wr_ready=0 and no flush occurs.

Test Plan:
- DATA_WIDTH=32: SB st_addr=0x1003, st_data=0x000000AB, mem_wr_ready=1 -> next cycle mem_wr_en=4'b1000, mem_wr_addr=0x1000, mem_wr_data=0xAB000000; following cycle empty=1.
- SH st_addr=0x1001, and SD st_addr=0x1000 -> st_misaligned=1 in the request cycle; count stays 0; mem_wr_en stays 0.
- mem_wr_ready=0, push SW to 0x0,0x4,0x8,0xC,0x10 (DEPTH=4) -> st_ready=0 after the 4th push, count=4, 5th is held. Raise ready -> writes 0x0,0x4,0x8,0xC on consecutive cycles, then the 5th is accepted and written.
- Queue SW 0x2000 with ready=0 -> ld_addr=0x2002 gives ld_hit=1; ld_addr=0x2004 gives ld_hit=0. After the write drains, ld_addr=0x2002 gives ld_hit=0.
- 3 entries queued, ready=0, flush=1 with a simultaneous valid SW -> next cycle count=0, empty=1, mem_wr_en=0; the new store is never written.
- rst_n low mid-drain (2 entries, ready=1) -> mem_wr_en=0 and count=0 immediately (asynchronous); after release st_ready=1, empty=1.
